// File: rtl/reset_sequencer_pkg.sv
// Shared types and limits for the reset sequencer.
package reset_sequencer_pkg;

  localparam int RST_SEQ_MAX_STAGES = 8;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    WAIT_DONE,
    RUN
  } rst_seq_state_t;

  function automatic int rst_seq_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Generic two-flop synchroniser with asynchronous active-low reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic arstn,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset-release controller: holds all domains in reset, then releases them one by one.
// Optional stage-done timeout with sticky error and full retry when RST_SEQ_TIMEOUT_EN is defined.
//
// state     | meaning
// HOLD      | all resets high, counting stable-lock cycles
// RELEASE   | one cycle, drop rst_out[idx]
// WAIT_DONE | wait for stage_done[idx]
// RUN       | every domain released, seq_done high
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  pll_locked,
  input  logic                  soft_rst,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic                  timeout_err
);

`ifdef RST_SEQ_TIMEOUT_EN
  localparam int CNT_MAX = rst_seq_max(HOLD_CYCLES, TIMEOUT_CYCLES);
`else
  localparam int CNT_MAX = HOLD_CYCLES;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);

  if (NUM_STAGES < 1 || NUM_STAGES > RST_SEQ_MAX_STAGES ||
      HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_err
    $error("reset_sequencer: parameter out of range");
  end

  logic rst_n_int;
  logic lock_s;

  // Bridge: assertion is immediate, release is two clk edges late.
  sync_2ff #(.RST_VAL(1'b0)) u_arst_bridge (
    .clk   (clk),
    .arstn (arstn),
    .d_i   (1'b1),
    .q_o   (rst_n_int)
  );

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk   (clk),
    .arstn (arstn),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  rst_seq_state_t        state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_STAGES-1:0] rst_out_q;
  logic                  busy_q;
  logic                  done_q;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  restart;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign restart = (state_q != HOLD) && (!lock_s || soft_rst);

`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic terr_q;
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      terr_q    <= 1'b0;
`endif
    end else if (restart) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (!lock_s) begin
            cnt_q <= '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        RELEASE: begin
          // Stages release in ascending order, so lower bits are already low.
          rst_out_q[idx_q] <= 1'b0;
          busy_q           <= (idx_q != LAST_IDX);
          cnt_q            <= '0;
          state_q          <= WAIT_DONE;
        end
        WAIT_DONE: begin
`ifdef RST_SEQ_TIMEOUT_EN
          if (cnt_q == TO_LAST) begin
            terr_q    <= 1'b1;
            state_q   <= HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            busy_q    <= 1'b1;
          end else
`endif
          if (stage_done[idx_q]) begin
            if (idx_q == LAST_IDX) begin
              state_q <= RUN;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= RELEASE;
            end
          end
`ifdef RST_SEQ_TIMEOUT_EN
          else begin
            cnt_q <= cnt_inc;
          end
`endif
        end
        RUN:     done_q  <= 1'b1;
        default: state_q <= HOLD;
      endcase
    end
  end

  assign rst_out  = rst_out_q;
  assign seq_busy = busy_q;
  assign seq_done = done_q;

endmodule
